cpu_fastram_responder: RTL and testbench
========================================

Name: cpu_fastram_responder

Overview:
- Memory-side responder for the CPU cache-port protocol (cpustate / cpuAddr / cpuL / cpuU / cpuWR / cpuRD / cpuena).
- It answers the same handshake that the SDRAM controller answers for the CPU, but from a local single-clock word RAM with fixed latency.
- It is used as a fast-RAM window beside the SDRAM controller, and as a deterministic stand-in for it when testing initiators.

Parameters:
- AW, 16, word address width; RAM depth is 2**AW 16-bit words.
- LATENCY, 2, cycles from request capture to the cpuena pulse; legal range 1..15.

Ports:
- clk  in  1  system clock (CPU/SDRAM controller clock domain).
- rst  in  1  reset, asynchronous, active-high.
- cpu_sel  in  1  address decode: the request targets this block.
- cpustate  in  2  request type: 00 opcode fetch, 10 data read, 11 write, 01 idle.
- cpuAddr  in  AW  word address.
- cpuL  in  1  lower byte strobe, active-low (write lane enable).
- cpuU  in  1  upper byte strobe, active-low (write lane enable).
- cpuWR  in  16  write data.
- cpuRD  out  16  read data.
- cpuena  out  1  one-cycle acknowledge.
- busy  out  1  high from request capture until return to IDLE.

Behaviour:
- Reset values: cpuena=0, cpuRD=16'h0000, busy=0, state=IDLE. Reset does not initialise RAM contents; they are preserved across reset.
- A request is active when cpu_sel=1 and cpustate!=01.
- States: IDLE, WAIT, ACK, HOLD.
- IDLE:
  - On an active request at edge N, latch addr, type, cpuWR, ~cpuU and ~cpuL.
  - Set busy=1.
  - Load the down-counter with LATENCY-1.
  - Go to WAIT, or go directly to ACK if LATENCY=1.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter reaches 0, go to ACK.
  - Abort: if cpustate==01 or cpu_sel==0 during WAIT, go to IDLE. On abort, busy=0, there is no RAM write and no cpuena.
- ACK:
  - Assert cpuena for exactly one cycle. It is high during the cycle after edge N+LATENCY-1, i.e. visible at N+LATENCY.
  - Reads (00/10): cpuRD = RAM[latched addr], updated in the same cycle that cpuena is high. cpuRD then holds until the next read ack.
  - Writes (11):
    - RAM upper byte is written only if latched ~cpuU=1; lower byte only if latched ~cpuL=1.
    - The write is committed at the ACK edge.
    - With both strobes inactive, RAM is unchanged but cpuena is still pulsed.
  - Next state: HOLD.
- HOLD:
  - cpuena=0; busy stays 1.
  - Wait until cpustate==01 or cpu_sel==0, then go to IDLE and set busy=0.
  - A new request needs at least one idle cycle seen in HOLD, so back-to-back requests without an idle gap are not re-acknowledged.
- Input handling:
  - Inputs sampled after capture are ignored, except for the abort/release checks.
  - A change of cpuAddr or cpuWR during WAIT does not affect the transaction.
- Address width: cpuAddr is used in full with no aliasing. The initiator narrows its own address bus to AW.
- Minimum request-to-request period: LATENCY+2 cycles.
- Reset asserted mid-transaction: all outputs and the FSM return to their reset values immediately (asynchronously). A write whose ACK edge has not occurred is not committed.

Test Plan:
- Write then read: write addr 0x0010 data 0x0123 strobes 00, then idle, then read 0x0010 → cpuena exactly LATENCY cycles after capture for each; cpuRD=0x0123.
- Byte lanes:
  - RAM[0x0020]=0xAAAA, write 0x1234 with cpuU=0, cpuL=1 → read returns 0x12AA.
  - Then write 0x5678 with cpuU=1, cpuL=0 → read returns 0x1278.
  - Then write with both strobes high → read returns 0x1278, and that write was still acked.
- Hold/release: keep cpustate=10 for 20 cycles after the ack → exactly one cpuena pulse and busy=1 throughout; drop to 01 → busy=0 the next cycle, and the next request is acked normally.
- Abort: with LATENCY=4, issue write 0xBEEF to 0x0030, then set cpustate=01 one cycle after capture → no cpuena; a later read of 0x0030 returns the prior value.
- Async reset: assert rst during WAIT of a write → cpuena=0, busy=0, cpuRD=0 without waiting for a clock edge. After release, a read of a previously written address returns the old data (the aborted write is not committed).
- Deselect: cpu_sel=0 with cpustate=11 → no ack and no RAM change; then LATENCY=1 sweep over 8 consecutive addresses → each ack comes 1 cycle after capture with correct data.

Source files
------------

// File: rtl/cpu_fastram_responder.sv
// Fixed-latency local word RAM that answers the CPU cache-port handshake
// (cpustate/cpuAddr/cpuena) the same way the SDRAM controller does.
module cpu_fastram_responder #(
    parameter int AW      = 16,
    parameter int LATENCY = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_sel,
    input  logic [1:0]    cpustate,
    input  logic [AW-1:0] cpuAddr,
    input  logic          cpuL,
    input  logic          cpuU,
    input  logic [15:0]   cpuWR,
    output logic [15:0]   cpuRD,
    output logic          cpuena,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, WAIT, ACK, HOLD} state_t;

    state_t          state;
    logic [3:0]      count;
    logic [AW-1:0]   lat_addr;
    logic            lat_write;
    logic [15:0]     lat_data;
    logic            lat_upper;
    logic            lat_lower;

    logic [15:0]     ram [0:(1<<AW)-1];

    logic            req_active;
    logic            release_req;
    logic            fire_now;
    logic            fire_wait;
    logic            ack_fire;
    logic [AW-1:0]   ack_addr;
    logic            ack_write;
    logic [15:0]     ack_data;
    logic            ack_upper;
    logic            ack_lower;

    assign req_active  = cpu_sel && (cpustate != 2'b01);
    assign release_req = !cpu_sel || (cpustate == 2'b01);

    // The acknowledge edge: straight from IDLE when LATENCY is 1, otherwise
    // the last WAIT cycle. With LATENCY 1 the live inputs are the capture.
    always_comb begin
        fire_now  = (state == IDLE) && req_active && (LATENCY == 1);
        fire_wait = (state == WAIT) && !release_req && (count == 4'd1);
        ack_fire  = !rst && (fire_now || fire_wait);
        if (fire_now) begin
            ack_addr  = cpuAddr;
            ack_write = (cpustate == 2'b11);
            ack_data  = cpuWR;
            ack_upper = !cpuU;
            ack_lower = !cpuL;
        end else begin
            ack_addr  = lat_addr;
            ack_write = lat_write;
            ack_data  = lat_data;
            ack_upper = lat_upper;
            ack_lower = lat_lower;
        end
    end

    // RAM has no reset so its contents survive a controller reset.
    always_ff @(posedge clk) begin
        if (ack_fire && ack_write) begin
            if (ack_upper) ram[ack_addr][15:8] <= ack_data[15:8];
            if (ack_lower) ram[ack_addr][7:0]  <= ack_data[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 4'd0;
            cpuena    <= 1'b0;
            cpuRD     <= 16'h0000;
            busy      <= 1'b0;
            lat_addr  <= '0;
            lat_write <= 1'b0;
            lat_data  <= 16'h0000;
            lat_upper <= 1'b0;
            lat_lower <= 1'b0;
        end else begin
            cpuena <= 1'b0;
            if (ack_fire) begin
                cpuena <= 1'b1;
                if (!ack_write) cpuRD <= ram[ack_addr];
            end
            case (state)
                IDLE: begin
                    if (req_active) begin
                        lat_addr  <= cpuAddr;
                        lat_write <= (cpustate == 2'b11);
                        lat_data  <= cpuWR;
                        lat_upper <= !cpuU;
                        lat_lower <= !cpuL;
                        busy      <= 1'b1;
                        count     <= 4'(LATENCY - 1);
                        state     <= (LATENCY == 1) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    if (release_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (count == 4'd1) begin
                        count <= 4'd0;
                        state <= ACK;
                    end else begin
                        count <= count - 4'd1;
                    end
                end
                ACK: state <= HOLD;
                // Requiring a release here keeps a held request from being re-acked.
                HOLD: begin
                    if (release_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_fastram_responder.sv
// Bench for cpu_fastram_responder: three instances (LATENCY 2, 4, 1) share
// the CPU bus and are told apart by their cpu_sel lines.
module tb_cpu_fastram_responder;

    typedef struct {
        int          dut;
        logic [1:0]  kind;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        u_n;
        logic        l_n;
        logic [15:0] exp_rd;
    } vec_t;

    typedef struct {
        int          dut;
        bit          is_read;
        logic [15:0] exp_rd;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  sel;
    logic [1:0]  cpustate;
    logic [15:0] cpuAddr;
    logic        cpuL;
    logic        cpuU;
    logic [15:0] cpuWR;
    logic [15:0] rd [3];
    logic [2:0]  ena;
    logic [2:0]  bsy;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    vec_t vecs[10];

    always #5 clk = ~clk;

    cpu_fastram_responder #(.AW(16), .LATENCY(2)) dut0 (
        .clk(clk), .rst(rst), .cpu_sel(sel[0]), .cpustate(cpustate), .cpuAddr(cpuAddr),
        .cpuL(cpuL), .cpuU(cpuU), .cpuWR(cpuWR), .cpuRD(rd[0]), .cpuena(ena[0]), .busy(bsy[0]));
    cpu_fastram_responder #(.AW(16), .LATENCY(4)) dut1 (
        .clk(clk), .rst(rst), .cpu_sel(sel[1]), .cpustate(cpustate), .cpuAddr(cpuAddr),
        .cpuL(cpuL), .cpuU(cpuU), .cpuWR(cpuWR), .cpuRD(rd[1]), .cpuena(ena[1]), .busy(bsy[1]));
    cpu_fastram_responder #(.AW(16), .LATENCY(1)) dut2 (
        .clk(clk), .rst(rst), .cpu_sel(sel[2]), .cpustate(cpustate), .cpuAddr(cpuAddr),
        .cpuL(cpuL), .cpuU(cpuU), .cpuWR(cpuWR), .cpuRD(rd[2]), .cpuena(ena[2]), .busy(bsy[2]));

    function automatic int lat_of(int d);
        case (d)
            0:       return 2;
            1:       return 4;
            default: return 1;
        endcase
    endfunction

    task automatic compare(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idleBus();
        sel      = 3'b000;
        cpustate = 2'b01;
        cpuAddr  = 16'h0000;
        cpuWR    = 16'h0000;
        cpuU     = 1'b1;
        cpuL     = 1'b1;
    endtask

    // Drives one request on a negedge and records what the DUT must answer.
    task automatic applyStimulus(vec_t v);
        exp_t e;
        sel        = 3'b000;
        sel[v.dut] = 1'b1;
        cpustate   = v.kind;
        cpuAddr    = v.addr;
        cpuWR      = v.wdata;
        cpuU       = v.u_n;
        cpuL       = v.l_n;
        e.dut      = v.dut;
        e.is_read  = (v.kind != 2'b11);
        e.exp_rd   = v.exp_rd;
        e.lat      = lat_of(v.dut);
        sb.push_back(e);
    endtask

    // Waits for the ack, checks latency/data, holds the request, then releases.
    task automatic checkOutput(int hold_cycles);
        exp_t e;
        int   c = 0;
        bit   got = 0;
        bit   busy_ok = 1;
        int   extra = 0;
        int   drops = 0;
        e = sb.pop_front();
        while (!got && c < 20) begin
            step();
            c++;
            if (ena[e.dut]) got = 1;
            else if (!bsy[e.dut]) busy_ok = 0;
            if (c == 1) begin
                cpuAddr = ~cpuAddr;
                cpuWR   = ~cpuWR;
            end
        end
        compare($sformatf("ack_latency_dut%0d", e.dut), c, e.lat);
        compare("busy_before_ack", busy_ok, 1);
        if (got && e.is_read) compare($sformatf("read_data_dut%0d", e.dut), rd[e.dut], e.exp_rd);
        for (int i = 0; i < hold_cycles; i++) begin
            step();
            if (ena[e.dut]) extra++;
            if (!bsy[e.dut]) drops++;
        end
        compare("no_reack_in_hold", extra, 0);
        compare("busy_in_hold", drops, 0);
        cpustate = 2'b01;
        step();
        compare("busy_release", bsy[e.dut], 0);
        idleBus();
    endtask

    task automatic doReq(int d, logic [1:0] k, logic [15:0] a, logic [15:0] w,
                         logic u_n, logic l_n, logic [15:0] exp_rd);
        vec_t v;
        v = '{d, k, a, w, u_n, l_n, exp_rd};
        applyStimulus(v);
        checkOutput(1);
    endtask

    initial begin
        int pulses;
        int busies;

        vecs[0] = '{0, 2'b11, 16'h0010, 16'h0123, 1'b0, 1'b0, 16'h0000};
        vecs[1] = '{0, 2'b10, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h0123};
        vecs[2] = '{0, 2'b11, 16'h0020, 16'hAAAA, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{0, 2'b11, 16'h0020, 16'h1234, 1'b0, 1'b1, 16'h0000};
        vecs[4] = '{0, 2'b10, 16'h0020, 16'h0000, 1'b1, 1'b1, 16'h12AA};
        vecs[5] = '{0, 2'b11, 16'h0020, 16'h5678, 1'b1, 1'b0, 16'h0000};
        vecs[6] = '{0, 2'b10, 16'h0020, 16'h0000, 1'b1, 1'b1, 16'h1278};
        vecs[7] = '{0, 2'b11, 16'h0020, 16'hFFFF, 1'b1, 1'b1, 16'h0000};
        vecs[8] = '{0, 2'b10, 16'h0020, 16'h0000, 1'b1, 1'b1, 16'h1278};
        vecs[9] = '{0, 2'b00, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h0123};

        idleBus();
        rst = 1'b1;
        step();
        step();
        for (int d = 0; d < 3; d++) begin
            compare($sformatf("reset_cpuena_dut%0d", d), ena[d], 0);
            compare($sformatf("reset_busy_dut%0d", d), bsy[d], 0);
            compare($sformatf("reset_cpuRD_dut%0d", d), rd[d], 16'h0000);
        end
        rst = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(1);
        end

        // Held read: only one pulse while cpustate stays 10, then a normal request.
        doReq(0, 2'b10, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h0123);
        applyStimulus('{0, 2'b10, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h0123});
        checkOutput(20);
        doReq(0, 2'b10, 16'h0020, 16'h0000, 1'b1, 1'b1, 16'h1278);

        // Abort on the LATENCY=4 instance.
        doReq(1, 2'b11, 16'h0030, 16'h1111, 1'b0, 1'b0, 16'h0000);
        doReq(1, 2'b10, 16'h0030, 16'h0000, 1'b1, 1'b1, 16'h1111);
        sel = 3'b010; cpustate = 2'b11; cpuAddr = 16'h0030; cpuWR = 16'hBEEF; cpuU = 1'b0; cpuL = 1'b0;
        step();
        cpustate = 2'b01;
        pulses = 0;
        busies = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ena[1]) pulses++;
            if (bsy[1]) busies++;
        end
        compare("abort_no_ack", pulses, 0);
        compare("abort_busy_low", busies, 0);
        idleBus();
        doReq(1, 2'b10, 16'h0030, 16'h0000, 1'b1, 1'b1, 16'h1111);

        // Asynchronous reset in the middle of a write's WAIT phase.
        sel = 3'b010; cpustate = 2'b11; cpuAddr = 16'h0030; cpuWR = 16'h2222; cpuU = 1'b0; cpuL = 1'b0;
        step();
        compare("busy_before_reset", bsy[1], 1);
        #2 rst = 1'b1;
        #1;
        compare("async_reset_cpuena", ena[1], 0);
        compare("async_reset_busy", bsy[1], 0);
        compare("async_reset_cpuRD", rd[1], 16'h0000);
        idleBus();
        step();
        rst = 1'b0;
        step();
        doReq(1, 2'b10, 16'h0030, 16'h0000, 1'b1, 1'b1, 16'h1111);

        // Deselected write traffic must be ignored by every instance.
        sel = 3'b000; cpustate = 2'b11; cpuAddr = 16'h0010; cpuWR = 16'hDEAD; cpuU = 1'b0; cpuL = 1'b0;
        pulses = 0;
        busies = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (ena != 3'b000) pulses++;
            if (bsy != 3'b000) busies++;
        end
        compare("deselect_no_ack", pulses, 0);
        compare("deselect_not_busy", busies, 0);
        idleBus();
        step();
        doReq(0, 2'b10, 16'h0010, 16'h0000, 1'b1, 1'b1, 16'h0123);

        // LATENCY=1 sweep over eight consecutive addresses.
        for (int i = 0; i < 8; i++)
            doReq(2, 2'b11, 16'h0040 + 16'(i), 16'hC000 + 16'(i) * 16'h0111, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 8; i++)
            doReq(2, 2'b10, 16'h0040 + 16'(i), 16'h0000, 1'b1, 1'b1, 16'hC000 + 16'(i) * 16'h0111);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
